// File: rtl/hazard_fwd_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit_if
// Purpose  : Decode-side bundle between the pipeline and the hazard/forwarding unit.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_fwd_unit_if #(
    parameter int XLEN  = 32,
    parameter int NRD   = 2,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    logic                  issue_valid_i;
    logic [4:0]            issue_rd_i;
    logic                  issue_wr_en_i;
    logic                  issue_is_load_i;
    logic [NRD*5-1:0]      issue_rs_i;
    logic [NRD-1:0]        issue_rs_used_i;
    logic [NRD*XLEN-1:0]   rf_data_i;
    logic [DEPTH*XLEN-1:0] stage_data_i;
    logic                  flush_i;
    logic                  mem_stall_i;
    logic [NRD*XLEN-1:0]   operand_o;
    logic                  stall_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport master (
        output issue_valid_i, issue_rd_i, issue_wr_en_i, issue_is_load_i,
        output issue_rs_i, issue_rs_used_i, rf_data_i, stage_data_i,
        output flush_i, mem_stall_i,
        input  operand_o, stall_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_wr_en_i, issue_is_load_i,
        input  issue_rs_i, issue_rs_used_i, rf_data_i, stage_data_i,
        input  flush_i, mem_stall_i,
        output operand_o, stall_o, stall_cnt_o, flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : In-flight write scoreboard, operand forwarding and load-use stall.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int XLEN       = 32,
    parameter int NRD        = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_fwd_unit_if.slave  bus
);
    logic [DEPTH-1:0]    sb_valid;
    logic [DEPTH-1:0]    sb_load;
    logic [4:0]          sb_rd [DEPTH];
    logic [NRD-1:0]      not_ready;
    logic [NRD*XLEN-1:0] operand;
    logic                stall;
    logic                alloc;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    for (genvar k = 0; k < NRD; k++) begin : g_opnd
        logic [4:0]      rs;
        logic [XLEN-1:0] rf_val;
        logic [XLEN-1:0] fwd_val;
        logic            hit;
        logic            ready;

        assign rs     = bus.issue_rs_i[5*k +: 5];
        assign rf_val = bus.rf_data_i[XLEN*k +: XLEN];

        always_comb begin
            hit     = 1'b0;
            ready   = 1'b0;
            fwd_val = rf_val;
            // Oldest first, so a younger match overrides even when it is not ready.
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (sb_valid[j] && (sb_rd[j] == rs)) begin
                    hit     = 1'b1;
                    ready   = !sb_load[j] || (j >= LOAD_STAGE);
                    fwd_val = bus.stage_data_i[XLEN*j +: XLEN];
                end
            end
            if (!bus.issue_rs_used_i[k] || (rs == 5'd0)) begin
                hit = 1'b0;
            end
        end

        assign operand[XLEN*k +: XLEN] = (hit && ready) ? fwd_val : rf_val;
        assign not_ready[k]            = hit && !ready;
    end

    assign stall = bus.issue_valid_i && !bus.flush_i && (|not_ready);
    assign alloc = bus.issue_valid_i && bus.issue_wr_en_i && (bus.issue_rd_i != 5'd0)
                   && !stall && !bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid  <= '0;
            sb_load   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                sb_rd[j] <= '0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!bus.mem_stall_i) begin
            sb_valid <= {sb_valid[DEPTH-2:0], alloc};
            sb_load  <= {sb_load[DEPTH-2:0], bus.issue_is_load_i};
            for (int j = DEPTH - 1; j >= 1; j--) begin
                sb_rd[j] <= sb_rd[j-1];
            end
            sb_rd[0] <= bus.issue_rd_i;
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bus.flush_i && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.operand_o   = operand;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_unit
// Purpose  : Bench for two hazard_fwd_unit builds (LOAD_STAGE 1/CNT_W 16 and LOAD_STAGE 2/CNT_W 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid, wr, ld, flush, mst;
    logic [4:0]  rd;
    logic [9:0]  rs;
    logic [1:0]  used;
    logic [63:0] rf;
    logic [95:0] sd;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.XLEN(32), .NRD(2), .DEPTH(3), .CNT_W(16)) ifa ();
    hazard_fwd_unit_if #(.XLEN(32), .NRD(2), .DEPTH(3), .CNT_W(4))  ifb ();

    assign ifa.issue_valid_i   = valid;  assign ifb.issue_valid_i   = valid;
    assign ifa.issue_rd_i      = rd;     assign ifb.issue_rd_i      = rd;
    assign ifa.issue_wr_en_i   = wr;     assign ifb.issue_wr_en_i   = wr;
    assign ifa.issue_is_load_i = ld;     assign ifb.issue_is_load_i = ld;
    assign ifa.issue_rs_i      = rs;     assign ifb.issue_rs_i      = rs;
    assign ifa.issue_rs_used_i = used;   assign ifb.issue_rs_used_i = used;
    assign ifa.rf_data_i       = rf;     assign ifb.rf_data_i       = rf;
    assign ifa.stage_data_i    = sd;     assign ifb.stage_data_i    = sd;
    assign ifa.flush_i         = flush;  assign ifb.flush_i         = flush;
    assign ifa.mem_stall_i     = mst;    assign ifb.mem_stall_i     = mst;

    hazard_fwd_unit #(.XLEN(32), .NRD(2), .DEPTH(3), .LOAD_STAGE(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa));
    hazard_fwd_unit #(.XLEN(32), .NRD(2), .DEPTH(3), .LOAD_STAGE(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb));

    // Reference model: list of in-flight writers, youngest first, per build.
    typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
    ent_t sb [2][3];
    int   scnt [2];
    int   fcnt [2];

    function automatic int lstage(int p); return (p == 0) ? 1 : 2; endfunction
    function automatic int cmax(int p);   return (p == 0) ? 65535 : 15; endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 3; j++) sb[p][j] = '{1'b0, 5'd0, 1'b0};
            scnt[p] = 0;
            fcnt[p] = 0;
        end
    endtask

    task automatic model_eval(input int p, output bit st, output logic [63:0] ops);
        bit blocked = 1'b0;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] r = rs[5*k +: 5];
            ops[32*k +: 32] = rf[32*k +: 32];
            if (used[k] && r != 5'd0) begin
                for (int j = 0; j < 3; j++) begin
                    if (sb[p][j].v && sb[p][j].rd == r) begin
                        if (sb[p][j].ld && j < lstage(p)) blocked = 1'b1;
                        else ops[32*k +: 32] = sd[32*j +: 32];
                        break;
                    end
                end
            end
        end
        st = valid && !flush && blocked;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs();
        bit st;
        logic [63:0] ops;
        model_eval(0, st, ops);
        chk("a_stall", 64'(ifa.stall_o), 64'(st));
        chk("a_operand", ifa.operand_o, ops);
        chk("a_stall_cnt", 64'(ifa.stall_cnt_o), 64'(scnt[0]));
        chk("a_flush_cnt", 64'(ifa.flush_cnt_o), 64'(fcnt[0]));
        model_eval(1, st, ops);
        chk("b_stall", 64'(ifb.stall_o), 64'(st));
        chk("b_operand", ifb.operand_o, ops);
        chk("b_stall_cnt", 64'(ifb.stall_cnt_o), 64'(scnt[1]));
        chk("b_flush_cnt", 64'(ifb.flush_cnt_o), 64'(fcnt[1]));
    endtask

    task automatic tick();
        bit st [2];
        logic [63:0] o;
        for (int p = 0; p < 2; p++) model_eval(p, st[p], o);
        @(posedge clk);
        if (!mst) begin
            for (int p = 0; p < 2; p++) begin
                for (int j = 2; j > 0; j--) sb[p][j] = sb[p][j-1];
                sb[p][0].v  = valid && wr && rd != 5'd0 && !st[p] && !flush;
                sb[p][0].rd = rd;
                sb[p][0].ld = ld;
                if (st[p] && scnt[p] < cmax(p)) scnt[p]++;
                if (flush && fcnt[p] < cmax(p)) fcnt[p]++;
            end
        end
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_outs();
        tick();
    endtask

    task automatic drive(input int v, input int d, input int w, input int l,
                         input int r0, input int r1, input int u, input int f, input int m);
        valid = 1'(v); rd = 5'(d); wr = 1'(w); ld = 1'(l);
        rs = {5'(r1), 5'(r0)}; used = 2'(u); flush = 1'(f); mst = 1'(m);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] expop(int src, int k);
        return (src == 3) ? 32'hB000_0000 + 32'(k) : 32'hA000_0000 + 32'(src);
    endfunction

    // Expectations below are for the LOAD_STAGE=1 build; src 0..2 = stage, 3 = regfile.
    typedef struct { int v, rd, w, l, r0, r1, u, f, m, es, s0, s1, sc, fc; } vec_t;
    vec_t tbl [19];

    initial begin
        tbl[0]  = '{0, 0, 0, 0,  1, 2, 3, 0, 0, 0, 3, 3, 0, 0};
        tbl[1]  = '{1, 1, 1, 0,  2, 3, 3, 0, 0, 0, 3, 3, 0, 0};
        tbl[2]  = '{1, 4, 1, 0,  1, 5, 3, 0, 0, 0, 0, 3, 0, 0};
        tbl[3]  = '{1, 1, 1, 0,  1, 4, 3, 0, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{1, 6, 1, 0,  1, 1, 3, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 7, 1, 1,  1, 0, 1, 0, 0, 0, 1, 3, 0, 0};
        tbl[6]  = '{1, 2, 1, 0,  7, 7, 3, 0, 0, 1, 3, 3, 0, 0};
        tbl[7]  = '{1, 2, 1, 0,  7, 7, 3, 0, 0, 0, 1, 1, 1, 0};
        tbl[8]  = '{1, 0, 1, 0,  2, 3, 3, 0, 0, 0, 0, 3, 1, 0};
        tbl[9]  = '{1, 5, 1, 0,  0, 2, 1, 0, 0, 0, 3, 3, 1, 0};
        tbl[10] = '{1, 8, 1, 1,  5, 0, 1, 0, 0, 0, 0, 3, 1, 0};
        tbl[11] = '{1, 9, 1, 0,  8, 5, 3, 1, 0, 0, 3, 1, 1, 0};
        tbl[12] = '{1, 10, 1, 1, 0, 0, 0, 0, 0, 0, 3, 3, 1, 1};
        tbl[13] = '{1, 11, 1, 0, 10, 0, 1, 0, 1, 1, 3, 3, 1, 1};
        tbl[14] = '{1, 11, 1, 0, 10, 0, 1, 0, 1, 1, 3, 3, 1, 1};
        tbl[15] = '{1, 11, 1, 0, 10, 0, 1, 0, 1, 1, 3, 3, 1, 1};
        tbl[16] = '{1, 11, 1, 0, 10, 0, 1, 0, 0, 1, 3, 3, 1, 1};
        tbl[17] = '{1, 11, 1, 0, 10, 0, 1, 0, 0, 0, 1, 3, 2, 1};
        tbl[18] = '{0, 0, 0, 0, 11, 0, 1, 0, 0, 0, 0, 3, 2, 1};

        rf = {32'hB000_0001, 32'hB000_0000};
        sd = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_outs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].rd, tbl[i].w, tbl[i].l, tbl[i].r0, tbl[i].r1,
                  tbl[i].u, tbl[i].f, tbl[i].m);
            @(negedge clk);
            chk("tbl_stall", 64'(ifa.stall_o), 64'(tbl[i].es));
            chk("tbl_op0", 64'(ifa.operand_o[31:0]), 64'(expop(tbl[i].s0, 0)));
            chk("tbl_op1", 64'(ifa.operand_o[63:32]), 64'(expop(tbl[i].s1, 1)));
            chk("tbl_stall_cnt", 64'(ifa.stall_cnt_o), 64'(tbl[i].sc));
            chk("tbl_flush_cnt", 64'(ifa.flush_cnt_o), 64'(tbl[i].fc));
            check_outs();
            tick();
        end

        // Load-use length depends on LOAD_STAGE: one bubble on A, two on B.
        do_reset();
        drive(1, 1, 1, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 2, 1, 0, 1, 1, 3, 0, 0);
        @(negedge clk);
        chk("ls_c1_a_stall", 64'(ifa.stall_o), 64'd1);
        chk("ls_c1_b_stall", 64'(ifb.stall_o), 64'd1);
        check_outs(); tick();
        @(negedge clk);
        chk("ls_c2_a_stall", 64'(ifa.stall_o), 64'd0);
        chk("ls_c2_a_op", ifa.operand_o, {32'hA000_0001, 32'hA000_0001});
        chk("ls_c2_a_cnt", 64'(ifa.stall_cnt_o), 64'd1);
        chk("ls_c2_b_stall", 64'(ifb.stall_o), 64'd1);
        check_outs(); tick();
        @(negedge clk);
        chk("ls_c3_b_stall", 64'(ifb.stall_o), 64'd0);
        chk("ls_c3_b_op", ifb.operand_o, {32'hA000_0002, 32'hA000_0002});
        chk("ls_c3_b_cnt", 64'(ifb.stall_cnt_o), 64'd2);
        check_outs(); tick();

        // Ten more load-use pairs: B sees 22 stall cycles and must pin at 15.
        for (int it = 0; it < 10; it++) begin
            drive(1, 1, 1, 1, 0, 0, 0, 0, 0);
            step();
            drive(1, 2, 1, 0, 1, 1, 3, 0, 0);
            repeat (3) step();
        end
        @(negedge clk);
        chk("sat_b_stall_cnt", 64'(ifb.stall_cnt_o), 64'd15);
        chk("sat_a_stall_cnt", 64'(ifa.stall_cnt_o), 64'd11);

        // Asynchronous reset in the middle of a load-use stall.
        drive(1, 1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 2, 1, 0, 1, 1, 3, 0, 0);
        @(negedge clk);
        chk("rst_pre_a_stall", 64'(ifa.stall_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_a_stall", 64'(ifa.stall_o), 64'd0);
        chk("rst_b_stall", 64'(ifb.stall_o), 64'd0);
        chk("rst_a_cnt", 64'(ifa.stall_cnt_o), 64'd0);
        chk("rst_b_cnt", 64'(ifb.stall_cnt_o), 64'd0);
        chk("rst_a_op", ifa.operand_o, rf);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            valid = ($urandom % 4) != 0;
            rd    = 5'($urandom % 8);
            wr    = ($urandom % 4) != 0;
            ld    = ($urandom % 3) == 0;
            rs    = {5'($urandom % 8), 5'($urandom % 8)};
            used  = 2'($urandom % 4);
            flush = ($urandom % 10) == 0;
            mst   = ($urandom % 8) == 0;
            rf    = {$urandom, $urandom};
            sd    = {$urandom, $urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
